// File: rtl/io_port_responder_if.sv
// CPU I/O port bus plus per-channel producer/consumer handshakes seen by io_port_responder.
interface io_port_responder_if #(
    parameter int unsigned DW     = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned AW     = 3
);
    logic [AW-1:0]        io_addr;
    logic [DW-1:0]        io_wdata;
    logic                 io_we;
    logic                 io_re;
    logic [DW-1:0]        io_rdata;
    logic [NPORTS*DW-1:0] in_data;
    logic [NPORTS-1:0]    in_valid;
    logic [NPORTS-1:0]    in_ready;
    logic [NPORTS*DW-1:0] out_data;
    logic [NPORTS-1:0]    out_valid;
    logic [NPORTS-1:0]    out_ready;

    modport slave (
        input  io_addr, io_wdata, io_we, io_re, in_data, in_valid, out_ready,
        output io_rdata, in_ready, out_data, out_valid
    );

    modport master (
        output io_addr, io_wdata, io_we, io_re, in_data, in_valid, out_ready,
        input  io_rdata, in_ready, out_data, out_valid
    );
endinterface

// File: rtl/io_port_responder.sv
// Peripheral-side responder for the CPU I/O port bus: one-entry input/output holding
// registers per channel, plus STATUS and sticky write-overflow registers for polling.
module io_port_responder #(
    parameter int unsigned DW     = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned AW     = 3
) (
    input logic                clk,
    input logic                reset,
    io_port_responder_if.slave bus
);
    localparam int unsigned STATUS_ADDR = NPORTS;
    localparam int unsigned OVF_ADDR    = NPORTS + 1;

    logic [NPORTS-1:0][DW-1:0] in_hold_q,  in_hold_d;
    logic [NPORTS-1:0][DW-1:0] out_hold_q, out_hold_d;
    logic [NPORTS-1:0]         in_full_q,  in_full_d;
    logic [NPORTS-1:0]         out_pending_q, out_pending_d;
    logic [NPORTS-1:0]         ovf_q, ovf_d;
    logic [NPORTS-1:0]         in_ready_c, out_valid_c, out_done_c;
    logic [DW-1:0]             rdata_c;

    // Handshakes are gated by reset so no transfer can complete while it is low.
    always_comb begin
        in_ready_c  = {NPORTS{reset}} & ~in_full_q;
        out_valid_c = {NPORTS{reset}} & out_pending_q;
        out_done_c  = out_valid_c & bus.out_ready;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_hold_q;
    assign bus.io_rdata  = rdata_c;

    // Read mux: data ports, STATUS, OVF; unmapped addresses read as zero.
    always_comb begin
        rdata_c = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (bus.io_addr == AW'(i)) rdata_c = in_hold_q[i];
        end
        if (bus.io_addr == AW'(STATUS_ADDR)) begin
            rdata_c = DW'({out_pending_q, in_full_q});
        end else if (bus.io_addr == AW'(OVF_ADDR)) begin
            rdata_c = DW'(ovf_q);
        end
    end

    always_comb begin
        in_hold_d     = in_hold_q;
        in_full_d     = in_full_q;
        out_hold_d    = out_hold_q;
        out_pending_d = out_pending_q;
        // An OVF read clears every flag; an overflow on the same edge is set afterwards and wins.
        ovf_d = (bus.io_re && bus.io_addr == AW'(OVF_ADDR)) ? '0 : ovf_q;

        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (bus.in_valid[i] && in_ready_c[i]) begin
                in_hold_d[i] = bus.in_data[i*DW +: DW];
                in_full_d[i] = 1'b1;
            end else if (bus.io_re && bus.io_addr == AW'(i)) begin
                in_full_d[i] = 1'b0;
            end

            if (out_done_c[i]) out_pending_d[i] = 1'b0;
            // A write into a slot being drained this cycle passes straight through.
            if (bus.io_we && bus.io_addr == AW'(i)) begin
                if (!out_pending_q[i] || out_done_c[i]) begin
                    out_hold_d[i]    = bus.io_wdata;
                    out_pending_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_hold_q     <= '0;
            in_full_q     <= '0;
            out_hold_q    <= '0;
            out_pending_q <= '0;
            ovf_q         <= '0;
        end else begin
            in_hold_q     <= in_hold_d;
            in_full_q     <= in_full_d;
            out_hold_q    <= out_hold_d;
            out_pending_q <= out_pending_d;
            ovf_q         <= ovf_d;
        end
    end
endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: directed scenarios plus a randomized run
// checked against a channel-level reference model with data scoreboards.
module tb_io_port_responder;
    localparam int unsigned DW = 8;
    localparam int unsigned NP = 4;
    localparam int unsigned AW = 3;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    io_port_responder_if #(.DW(DW), .NPORTS(NP), .AW(AW)) bus ();

    io_port_responder #(.DW(DW), .NPORTS(NP), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference-model state for the randomized run.
    logic [7:0] q_in  [NP][$];
    logic [7:0] q_out [NP][$];
    logic [7:0] m_last_in [NP];
    bit         m_full [NP];
    bit         m_pend [NP];
    bit         m_ovf  [NP];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_addr   = '0;
        bus.io_wdata  = '0;
        bus.io_we     = 1'b0;
        bus.io_re     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic peek(input int a, output logic [7:0] v);
        bus.io_addr = AW'(a);
        #1;
        v = bus.io_rdata;
    endtask

    task automatic cpu_read(input int a, output logic [7:0] v);
        bus.io_addr = AW'(a);
        bus.io_re   = 1'b1;
        #1;
        v = bus.io_rdata;
        cyc();
        bus.io_re = 1'b0;
    endtask

    task automatic cpu_write(input int a, input logic [7:0] d);
        bus.io_addr  = AW'(a);
        bus.io_wdata = d;
        bus.io_we    = 1'b1;
        cyc();
        bus.io_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        idle_inputs();
        reset = 1'b0;
        bus.in_valid = 4'hF;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== 4'h0) begin
                n_fail++; $display("FAIL reset_in_ready: got %h want 0", bus.in_ready);
            end
            n_tests++;
            if (bus.out_valid !== 4'h0) begin
                n_fail++; $display("FAIL reset_out_valid: got %h want 0", bus.out_valid);
            end
            @(posedge clk);
        end
        #1;
        peek(NP, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", v); end
        peek(NP + 1, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ovf: got %h want 00", v); end
        bus.in_valid = '0;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 4'hF) begin
            n_fail++; $display("FAIL release_in_ready: got %h want f", bus.in_ready);
        end
        cyc();
    endtask

    task automatic test_input_capture();
        logic [7:0] v;
        do_reset();
        bus.in_data[2*DW +: DW] = 8'hA5;
        bus.in_valid = 4'b0100;
        cyc();
        bus.in_valid = '0;
        n_tests++;
        if (bus.in_ready[2] !== 1'b0) begin
            n_fail++; $display("FAIL cap_ready_low: got %b want 0", bus.in_ready[2]);
        end
        peek(NP, v);
        n_tests++;
        if (v !== 8'h04) begin n_fail++; $display("FAIL cap_status: got %h want 04", v); end
        cpu_read(2, v);
        n_tests++;
        if (v !== 8'hA5) begin n_fail++; $display("FAIL cap_read: got %h want a5", v); end
        peek(NP, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL cap_status_clr: got %h want 00", v); end
        n_tests++;
        if (bus.in_ready[2] !== 1'b1) begin
            n_fail++; $display("FAIL cap_ready_back: got %b want 1", bus.in_ready[2]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] v;
        do_reset();
        bus.in_data[7:0] = 8'h11;
        bus.in_valid = 4'b0001;
        cyc();
        bus.in_data[7:0] = 8'h22;
        cyc();
        cyc();
        peek(0, v);
        n_tests++;
        if (v !== 8'h11) begin n_fail++; $display("FAIL bp_hold: got %h want 11", v); end
        cpu_read(0, v);
        n_tests++;
        if (v !== 8'h11) begin n_fail++; $display("FAIL bp_first_read: got %h want 11", v); end
        n_tests++;
        if (bus.in_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready_after_read: got %b want 1", bus.in_ready[0]);
        end
        peek(0, v);
        n_tests++;
        if (v !== 8'h11) begin n_fail++; $display("FAIL bp_not_yet: got %h want 11", v); end
        cyc();
        bus.in_valid = '0;
        cpu_read(0, v);
        n_tests++;
        if (v !== 8'h22) begin n_fail++; $display("FAIL bp_second_read: got %h want 22", v); end
    endtask

    task automatic test_output_overflow();
        logic [7:0] v;
        do_reset();
        cpu_write(1, 8'h3C);
        n_tests++;
        if (bus.out_valid !== 4'b0010) begin
            n_fail++; $display("FAIL out_valid: got %h want 2", bus.out_valid);
        end
        n_tests++;
        if (bus.out_data[15:8] !== 8'h3C) begin
            n_fail++; $display("FAIL out_data: got %h want 3c", bus.out_data[15:8]);
        end
        peek(NP, v);
        n_tests++;
        if (v !== 8'h20) begin n_fail++; $display("FAIL out_status: got %h want 20", v); end
        cpu_write(1, 8'hFF);
        n_tests++;
        if (bus.out_data[15:8] !== 8'h3C) begin
            n_fail++; $display("FAIL ovf_data_kept: got %h want 3c", bus.out_data[15:8]);
        end
        cpu_read(NP + 1, v);
        n_tests++;
        if (v !== 8'h02) begin n_fail++; $display("FAIL ovf_read: got %h want 02", v); end
        peek(NP + 1, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL ovf_cleared: got %h want 00", v); end
        peek(7, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h want 00", v); end
    endtask

    task automatic test_pass_through();
        logic [7:0] v;
        do_reset();
        cpu_write(3, 8'h01);
        bus.out_ready = 4'b1000;
        bus.io_addr   = AW'(3);
        bus.io_wdata  = 8'h02;
        bus.io_we     = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_data[31:24] !== 8'h01) begin
            n_fail++; $display("FAIL pt_consumer: got v=%b d=%h want v=1 d=01",
                               bus.out_valid[3], bus.out_data[31:24]);
        end
        cyc();
        bus.io_we = 1'b0;
        bus.out_ready = '0;
        n_tests++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_data[31:24] !== 8'h02) begin
            n_fail++; $display("FAIL pt_next: got v=%b d=%h want v=1 d=02",
                               bus.out_valid[3], bus.out_data[31:24]);
        end
        peek(NP + 1, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL pt_ovf: got %h want 00", v); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] v;
        do_reset();
        bus.in_data[15:8] = 8'h77;
        bus.in_valid = 4'b0010;
        cyc();
        bus.in_valid = '0;
        cpu_write(0, 8'h55);
        peek(NP, v);
        n_tests++;
        if (v !== 8'h12) begin n_fail++; $display("FAIL mr_status_before: got %h want 12", v); end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 4'h0 || bus.out_valid !== 4'h0) begin
            n_fail++; $display("FAIL mr_during: got rdy=%h vld=%h want 0 0", bus.in_ready, bus.out_valid);
        end
        cyc();
        reset = 1'b1;
        peek(NP, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL mr_status_after: got %h want 00", v); end
        n_tests++;
        if (bus.in_ready !== 4'hF || bus.out_valid !== 4'h0) begin
            n_fail++; $display("FAIL mr_after: got rdy=%h vld=%h want f 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_rd, d;
        logic [NP-1:0] exp_rdy, exp_vld;
        int a;
        bit accept, done;
        do_reset();
        for (int i = 0; i < NP; i++) begin
            q_in[i].delete(); q_out[i].delete();
            m_last_in[i] = 8'h00; m_full[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        end
        for (int c = 0; c < 500; c++) begin
            bus.in_valid  = NP'($urandom);
            bus.out_ready = NP'($urandom);
            for (int i = 0; i < NP; i++) bus.in_data[i*DW +: DW] = 8'($urandom);
            a = int'($urandom_range(0, 7));
            bus.io_addr  = AW'(a);
            bus.io_wdata = 8'($urandom);
            bus.io_re    = ($urandom_range(0, 2) == 0);
            bus.io_we    = ($urandom_range(0, 2) == 0);
            #1;
            exp_rdy = '0; exp_vld = '0;
            for (int i = 0; i < NP; i++) begin
                exp_rdy[i] = !m_full[i];
                exp_vld[i] = m_pend[i];
            end
            n_tests++;
            if (bus.in_ready !== exp_rdy || bus.out_valid !== exp_vld) begin
                n_fail++; $display("FAIL rnd_flags c=%0d: got rdy=%h vld=%h want %h %h",
                                   c, bus.in_ready, bus.out_valid, exp_rdy, exp_vld);
            end
            if (a < NP) exp_rd = m_last_in[a];
            else if (a == NP) exp_rd = {exp_vld, ~exp_rdy};
            else if (a == NP + 1) exp_rd = {4'h0, m_ovf[3], m_ovf[2], m_ovf[1], m_ovf[0]};
            else exp_rd = 8'h00;
            n_tests++;
            if (bus.io_rdata !== exp_rd) begin
                n_fail++; $display("FAIL rnd_rdata c=%0d a=%0d: got %h want %h", c, a, bus.io_rdata, exp_rd);
            end
            // Advance the model using the cycle's inputs.
            if (bus.io_re && a == NP + 1) for (int i = 0; i < NP; i++) m_ovf[i] = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_full[i] && bus.io_re && a == i) begin
                    d = q_in[i].pop_front();
                    n_tests++;
                    if (bus.io_rdata !== d) begin
                        n_fail++; $display("FAIL rnd_in_sb ch%0d: got %h want %h", i, bus.io_rdata, d);
                    end
                    m_full[i] = 0;
                end else if (!m_full[i] && bus.in_valid[i]) begin
                    q_in[i].push_back(bus.in_data[i*DW +: DW]);
                    m_last_in[i] = bus.in_data[i*DW +: DW];
                    m_full[i] = 1;
                end
                done = m_pend[i] && bus.out_ready[i];
                if (done) begin
                    d = q_out[i].pop_front();
                    n_tests++;
                    if (bus.out_data[i*DW +: DW] !== d) begin
                        n_fail++; $display("FAIL rnd_out_sb ch%0d: got %h want %h",
                                           i, bus.out_data[i*DW +: DW], d);
                    end
                    m_pend[i] = 0;
                end
                if (bus.io_we && a == i) begin
                    accept = !m_pend[i];
                    if (accept) begin
                        q_out[i].push_back(bus.io_wdata);
                        m_pend[i] = 1;
                    end else begin
                        m_ovf[i] = 1;
                    end
                end
            end
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_input_capture();
        test_backpressure();
        test_output_overflow();
        test_pass_through();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
